sequence_detector_1011: RTL and testbench
=========================================

Name: sequence_detector_1011

Overview:
Serial-bit pattern detector for the sequence 1-0-1-1, implemented as a Moore FSM with overlapping detection. It samples one input bit per rising clock edge. It raises a one-cycle detection flag whenever the four most recent sampled bits equal 1011. It sits on a serial data path as a stand-alone monitor; the flag is purely state-derived, with no combinational path from input to output.

Parameters:
- CNT_W, default 8: width of the detection counter (used only when the optional feature is compiled in).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- sequence_in  input  1  serial data bit, sampled on every rising edge of clock.
- detector_out  output  1  high for exactly one cycle while the FSM is in state S1011.
- detect_count  output  CNT_W  number of detections so far (see Optional Feature).

Behaviour:
- States (binary-encoded, 3 bits):
  - ZERO = 0: no useful prefix.
  - S1 = 1: seen "1".
  - S10 = 2: seen "10".
  - S101 = 3: seen "101".
  - S1011 = 4: seen "1011".
- Transitions, written as current state: next on sequence_in=0 / next on sequence_in=1:
  - ZERO: ZERO / S1
  - S1: S10 / S1
  - S10: ZERO / S101
  - S101: S10 / S1011
  - S1011: S10 / S1
- Overlap: the trailing "1" of a match seeds the next match. 1011011 therefore yields two detections.
- Unused encodings 5..7 go to ZERO on the next edge. detector_out is 0 in those states.
- detector_out = (state == S1011). It is Moore, so it changes only on clock edges.
- Latency: the edge that samples the final "1" enters S1011. detector_out is high from that edge until the next edge (one full cycle).
- Back-to-back detections cannot be closer than 3 cycles apart. detector_out never stays high for 2 consecutive cycles.
- Reset (reset=0):
  - State is forced to ZERO immediately, independent of clock.
  - detector_out=0 and detect_count=0 immediately.
  - Reset asserted mid-sequence discards any partial match.
- Reset release: the first rising edge with reset=1 samples sequence_in normally.
- sequence_in is assumed synchronous to clock; no internal synchronizer.
- Next-state logic is combinational. The state register is the only sequential element, plus the counter when that feature is enabled.

Optional Feature:
- Macro SEQ_DET_COUNT_EN.
- Defined:
  - detect_count increments by 1 on every edge that enters S1011.
  - It saturates at 2^CNT_W-1 and never wraps.
  - It is cleared only by reset.
- Undefined:
  - No counter register is synthesized.
  - detect_count is tied to 0.
  - FSM behaviour is identical in both builds.

Test Plan:
- Reset: hold reset=0 for 3 cycles with sequence_in toggling -> detector_out=0, detect_count=0 throughout. Release reset with sequence_in=0 for 4 cycles -> detector_out stays 0.
- Single match: drive 1,0,1,1 on consecutive edges, then 0 -> detector_out=1 for exactly the one cycle after the 4th edge, then 0. detect_count=1 (feature on).
- Overlap: drive 1,0,1,1,0,1,1 -> two one-cycle pulses, after bit 4 and after bit 7. detect_count=2.
- Non-matches:
  - Drive 1,0,0,1,1,1 -> detector_out never asserts.
  - Drive 1,1,0,1,1 -> one pulse after bit 5 (S1 self-loop).
- Reset mid-operation: drive 1,0,1, assert reset asynchronously between edges, release, then drive 1 -> no detection. Then drive 0,1,1 -> one pulse.
- Saturation (feature on, CNT_W=2): produce 5 matches -> detect_count reads 1,2,3,3,3. Feature off -> detect_count=0 always, while pulses are identical to the feature-on build.

Source files
------------

// File: rtl/sequence_detector_1011.sv
// Overlapping Moore detector for the serial pattern 1-0-1-1 with a registered one-cycle flag.
// Optional saturating detection counter is compiled in with `define SEQ_DET_COUNT_EN.
module sequence_detector_1011 #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sequence_in,
  output logic             detector_out,
  output logic [CNT_W-1:0] detect_count
);

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    S1    = 3'd1,
    S10   = 3'd2,
    S101  = 3'd3,
    S1011 = 3'd4
  } state_e;

  state_e state_q;
  state_e state_d;
  logic   detector_out_q;
  logic   detector_out_d;

  // Next-state logic; unused encodings fall back to ZERO.
  always_comb begin
    state_d = ZERO;
    case (state_q)
      ZERO: begin
        if (sequence_in) state_d = S1;
        else             state_d = ZERO;
      end
      S1: begin
        if (sequence_in) state_d = S1;
        else             state_d = S10;
      end
      S10: begin
        if (sequence_in) state_d = S101;
        else             state_d = ZERO;
      end
      S101: begin
        if (sequence_in) state_d = S1011;
        else             state_d = S10;
      end
      S1011: begin
        // The trailing 1 of a match seeds the next one.
        if (sequence_in) state_d = S1;
        else             state_d = S10;
      end
      default: state_d = ZERO;
    endcase
    detector_out_d = (state_d == S1011);
  end

  // FSM state register; the flag is registered alongside it so it equals (state_q == S1011).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ZERO;
      detector_out_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      detector_out_q <= detector_out_d;
    end
  end

  assign detector_out = detector_out_q;

`ifdef SEQ_DET_COUNT_EN
  logic [CNT_W-1:0] detect_count_q;
  logic [CNT_W-1:0] detect_count_d;

  // Saturating increment on every edge that enters S1011.
  always_comb begin
    detect_count_d = detect_count_q;
    if (detector_out_d && (detect_count_q != {CNT_W{1'b1}})) begin
      detect_count_d = detect_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      detect_count_d = detect_count_q;
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      detect_count_q <= {CNT_W{1'b0}};
    end else begin
      detect_count_q <= detect_count_d;
    end
  end

  assign detect_count = detect_count_q;
`else
  assign detect_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_sequence_detector_1011.sv
// Directed bench for sequence_detector_1011 (CNT_W=2), valid with or without SEQ_DET_COUNT_EN.
module tb_sequence_detector_1011;

  logic       clock;
  logic       reset;
  logic       sequence_in;
  logic       detector_out;
  logic [1:0] detect_count;

  int checks;
  int errors;
  logic [1:0] exp_cnt;

  sequence_detector_1011 #(.CNT_W(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .sequence_in  (sequence_in),
    .detector_out (detector_out),
    .detect_count (detect_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic drive_bit(input logic b);
    @(negedge clock);
    sequence_in = b;
    @(posedge clock);
    #1;
  endtask

  task automatic model_hit();
`ifdef SEQ_DET_COUNT_EN
    if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_bit(i[0] ? 1'b0 : 1'b1);
      checks++;
      if (detector_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_out cyc%0d: got %b expected 0", i, detector_out);
      end
      checks++;
      if (detect_count !== 2'd0) begin
        errors++;
        $display("FAIL reset_cnt cyc%0d: got %0d expected 0", i, detect_count);
      end
    end
    @(negedge clock);
    sequence_in = 1'b0;
    reset = 1'b1;
    exp_cnt = 2'd0;
    for (int i = 0; i < 4; i++) begin
      drive_bit(1'b0);
      checks++;
      if (detector_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_release cyc%0d: got %b expected 0", i, detector_out);
      end
    end
  endtask

  task automatic test_single();
    logic [6:0] v;
    logic [6:0] e;
    v = 7'b0010110;
    e = 7'b0000010;
    for (int i = 6; i >= 0; i--) begin
      drive_bit(v[i]);
      if (e[i]) model_hit();
      checks++;
      if (detector_out !== e[i]) begin
        errors++;
        $display("FAIL single bit%0d: detector_out=%b expected %b", 6 - i, detector_out, e[i]);
      end
      checks++;
      if (detect_count !== exp_cnt) begin
        errors++;
        $display("FAIL single_cnt bit%0d: got %0d expected %0d", 6 - i, detect_count, exp_cnt);
      end
    end
  endtask

  task automatic test_overlap();
    logic [8:0] v;
    logic [8:0] e;
    v = 9'b001011011;
    e = 9'b000001001;
    for (int i = 8; i >= 0; i--) begin
      drive_bit(v[i]);
      if (e[i]) model_hit();
      checks++;
      if (detector_out !== e[i]) begin
        errors++;
        $display("FAIL overlap bit%0d: detector_out=%b expected %b", 8 - i, detector_out, e[i]);
      end
      checks++;
      if (detect_count !== exp_cnt) begin
        errors++;
        $display("FAIL overlap_cnt bit%0d: got %0d expected %0d", 8 - i, detect_count, exp_cnt);
      end
    end
  endtask

  task automatic test_non_match();
    logic [14:0] v;
    logic [14:0] e;
    // 0,0,1,0,0,1,1,1 never matches; 0,0,1,1,0,1,1 matches only on the last bit.
    v = 15'b001001110011011;
    e = 15'b000000000000001;
    for (int i = 14; i >= 0; i--) begin
      drive_bit(v[i]);
      if (e[i]) model_hit();
      checks++;
      if (detector_out !== e[i]) begin
        errors++;
        $display("FAIL non_match bit%0d: detector_out=%b expected %b", 14 - i, detector_out, e[i]);
      end
    end
    checks++;
    if (detect_count !== exp_cnt) begin
      errors++;
      $display("FAIL non_match_cnt: got %0d expected %0d", detect_count, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] v;
    logic [11:0] e;
    v = 12'b001011011011;
    e = 12'b000001001001;
    for (int i = 11; i >= 0; i--) begin
      drive_bit(v[i]);
      if (e[i]) model_hit();
      checks++;
      if (detector_out !== e[i]) begin
        errors++;
        $display("FAIL back_to_back bit%0d: detector_out=%b expected %b", 11 - i, detector_out, e[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] v;
    logic [3:0] w;
    logic [3:0] e;
    v = 3'b101;
    drive_bit(1'b0);
    drive_bit(1'b0);
    for (int i = 2; i >= 0; i--) drive_bit(v[i]);
    #2;
    reset = 1'b0;
    #1;
    exp_cnt = 2'd0;
    checks++;
    if (detector_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_out: got %b expected 0", detector_out);
    end
    checks++;
    if (detect_count !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset_cnt: got %0d expected 0", detect_count);
    end
    @(negedge clock);
    sequence_in = 1'b1;
    reset = 1'b1;
    w = 4'b1011;
    e = 4'b0001;
    @(posedge clock);
    #1;
    checks++;
    if (detector_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_first1: got %b expected 0", detector_out);
    end
    for (int i = 2; i >= 0; i--) begin
      drive_bit(w[i]);
      if (e[i]) model_hit();
      checks++;
      if (detector_out !== e[i]) begin
        errors++;
        $display("FAIL mid_reset_seq bit%0d: detector_out=%b expected %b", 2 - i, detector_out, e[i]);
      end
    end
    checks++;
    if (detect_count !== exp_cnt) begin
      errors++;
      $display("FAIL mid_reset_seq_cnt: got %0d expected %0d", detect_count, exp_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [4:0] v;
    logic [4:0] e;
    @(negedge clock);
    reset = 1'b0;
    sequence_in = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    exp_cnt = 2'd0;
    v = 5'b01011;
    e = 5'b00001;
    for (int m = 0; m < 5; m++) begin
      for (int i = 4; i >= 0; i--) begin
        drive_bit(v[i]);
        if (e[i]) model_hit();
        checks++;
        if (detector_out !== e[i]) begin
          errors++;
          $display("FAIL sat_out match%0d bit%0d: got %b expected %b", m, 4 - i, detector_out, e[i]);
        end
      end
      checks++;
      if (detect_count !== exp_cnt) begin
        errors++;
        $display("FAIL sat_cnt match%0d: got %0d expected %0d", m, detect_count, exp_cnt);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_cnt = 2'd0;
    reset = 1'b0;
    sequence_in = 1'b0;
    #1;
    checks++;
    if (detector_out !== 1'b0) begin
      errors++;
      $display("FAIL power_on_out: got %b expected 0", detector_out);
    end
    test_reset();
    test_single();
    test_overlap();
    test_non_match();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
